bsh_cmd_fifo: RTL

//   Command buffer directly upstream of the 32-bit barrel shifter. Accepts shift

---
 rtl/bsh_cmd_fifo_if.sv | 29 ++
 rtl/bsh_cmd_fifo.sv | 75 +++++++
 2 files changed

// File: rtl/bsh_cmd_fifo_if.sv
// Command/handshake bundle between a command source, bsh_cmd_fifo and the barrel shifter.
// The slave modport is the FIFO side; the master modport is the source/shifter side.
interface bsh_cmd_fifo_if #(
  parameter int DW = 32,
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_dir;
  logic [5:0]    in_sh;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_in;
  logic          dir;
  logic [4:0]    sh;
  logic          sh_oflow;
  logic [AW:0]   count;

  modport slave (
    input  in_valid, in_data, in_dir, in_sh, out_ready,
    output in_ready, out_valid, data_in, dir, sh, sh_oflow, count
  );

  modport master (
    output in_valid, in_data, in_dir, in_sh, out_ready,
    input  in_ready, out_valid, data_in, dir, sh, sh_oflow, count
  );
endinterface

// File: rtl/bsh_cmd_fifo.sv
// Show-ahead command FIFO feeding the 32-bit barrel shifter.
// Shift amounts >= 32 are saturated to 31 at write time and flagged via sh_oflow.
module bsh_cmd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  bsh_cmd_fifo_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] data_q  [DEPTH];
  logic          dir_q   [DEPTH];
  logic [4:0]    sh_q    [DEPTH];
  logic          oflow_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic       full, empty, push, pop;
  logic [4:0] sh_sat;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign push   = bus.in_valid && !full;
  assign pop    = bus.out_ready && !empty;
  assign sh_sat = bus.in_sh[5] ? 5'd31 : bus.in_sh[4:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        dir_q[i]   <= 1'b0;
        sh_q[i]    <= '0;
        oflow_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        data_q[wr_ptr_q]  <= bus.in_data;
        dir_q[wr_ptr_q]   <= bus.in_dir;
        sh_q[wr_ptr_q]    <= sh_sat;
        oflow_q[wr_ptr_q] <= bus.in_sh[5];
      end
    end
  end

  // A pop while full frees the slot only after the edge, so in_ready is purely !full.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.data_in   = data_q[rd_ptr_q];
  assign bus.dir       = dir_q[rd_ptr_q];
  assign bus.sh        = sh_q[rd_ptr_q];
  assign bus.sh_oflow  = oflow_q[rd_ptr_q];
  assign bus.count     = count_q;
endmodule
